// File: rtl/pcie_axis_pkt_rr_arb.sv
// Packet-atomic round-robin arbiter merging NUM_REQ PCIe AXI-S
// request streams into one registered AXI-S output stream.
module pcie_axis_pkt_rr_arb #(
  parameter  int NUM_REQ     = 4,
  parameter  int TDATA_WIDTH = 512,
  parameter  int TUSER_WIDTH = 10,
  localparam int IDW         = $clog2(NUM_REQ),
  localparam int KW          = TDATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_en,
  input  logic [NUM_REQ-1:0]             in_tvalid,
  output logic [NUM_REQ-1:0]             in_tready,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_REQ*KW-1:0]          in_tkeep,
  input  logic [NUM_REQ-1:0]             in_tlast,
  input  logic [NUM_REQ*TUSER_WIDTH-1:0] in_tuser,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic [TDATA_WIDTH-1:0]         out_tdata,
  output logic [KW-1:0]                  out_tkeep,
  output logic                           out_tlast,
  output logic [TUSER_WIDTH-1:0]         out_tuser,
  output logic [IDW-1:0]                 owner,
  output logic                           busy,
  output logic [31:0]                    pkt_cnt
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t                 r_state;
  logic [IDW-1:0]         r_last_grant;
  logic [IDW-1:0]         r_owner;
  logic                   r_busy;
  logic [31:0]            r_pkt_cnt;
  logic                   r_out_tvalid;
  logic [TDATA_WIDTH-1:0] r_out_tdata;
  logic [KW-1:0]          r_out_tkeep;
  logic                   r_out_tlast;
  logic [TUSER_WIDTH-1:0] r_out_tuser;

  logic                   w_slot_free;
  logic [NUM_REQ-1:0]     w_elig;
  logic [NUM_REQ-1:0]     w_grant;
  logic [NUM_REQ-1:0]     w_ready;
  logic [IDW-1:0]         w_gidx;
  logic                   w_found;
  logic                   w_acc;
  logic [TDATA_WIDTH-1:0] w_sel_data;
  logic [KW-1:0]          w_sel_keep;
  logic                   w_sel_last;
  logic [TUSER_WIDTH-1:0] w_sel_user;

  assign w_slot_free = ~r_out_tvalid | out_tready;
  assign w_elig      = in_tvalid & req_en;

  // Rotating search starts just after the last winner.
  always_comb begin
    int j;
    j       = 0;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    if (r_state == S_BUSY) begin
      w_gidx           = r_owner;
      w_grant[r_owner] = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        j = (int'(r_last_grant) + k) % NUM_REQ;
        if (!w_found && w_elig[j]) begin
          w_found = 1'b1;
          w_gidx  = IDW'(j);
        end
      end
      if (w_found) begin
        w_grant[w_gidx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_keep = '0;
    w_sel_last = 1'b0;
    w_sel_user = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == IDW'(i)) begin
        w_sel_data = in_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        w_sel_keep = in_tkeep[i*KW +: KW];
        w_sel_last = in_tlast[i];
        w_sel_user = in_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
      end
    end
  end

  // Requesters see no ready while the block is held in reset.
  assign w_ready   = (rst_n && w_slot_free) ? w_grant : '0;
  assign w_acc     = |(in_tvalid & w_ready);
  assign in_tready = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_busy       <= 1'b0;
      r_pkt_cnt    <= '0;
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tkeep  <= '0;
      r_out_tlast  <= 1'b0;
      r_out_tuser  <= '0;
    end else begin
      if (r_out_tvalid && out_tready && r_out_tlast) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (w_slot_free) begin
        r_out_tvalid <= w_acc;
        r_out_tdata  <= w_sel_data;
        r_out_tkeep  <= w_sel_keep;
        r_out_tlast  <= w_sel_last;
        r_out_tuser  <= w_sel_user;
      end
      if (w_acc) begin
        case (r_state)
          S_IDLE: begin
            r_last_grant <= w_gidx;
            r_owner      <= w_gidx;
            if (!w_sel_last) begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
            end
          end
          S_BUSY: begin
            if (w_sel_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_tvalid = r_out_tvalid;
  assign out_tdata  = r_out_tdata;
  assign out_tkeep  = r_out_tkeep;
  assign out_tlast  = r_out_tlast;
  assign out_tuser  = r_out_tuser;
  assign owner      = r_owner;
  assign busy       = r_busy;
  assign pkt_cnt    = r_pkt_cnt;

endmodule

// File: tb/tb_pcie_axis_pkt_rr_arb.sv
// Directed bench for pcie_axis_pkt_rr_arb with a cycle-level
// reference model and hand-computed packet order expectations.
module tb_pcie_axis_pkt_rr_arb;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int UW = 10;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_en;
  logic [N-1:0]    in_tvalid;
  logic [N-1:0]    in_tready;
  logic [N*DW-1:0] in_tdata;
  logic [N*KW-1:0] in_tkeep;
  logic [N-1:0]    in_tlast;
  logic [N*UW-1:0] in_tuser;
  logic            out_tvalid;
  logic            out_tready;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic            out_tlast;
  logic [UW-1:0]   out_tuser;
  logic [1:0]      owner;
  logic            busy;
  logic [31:0]     pkt_cnt;

  always #5 clk = ~clk;

  pcie_axis_pkt_rr_arb #(
    .NUM_REQ    (N),
    .TDATA_WIDTH(DW),
    .TUSER_WIDTH(UW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_en    (req_en),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tdata  (in_tdata),
    .in_tkeep  (in_tkeep),
    .in_tlast  (in_tlast),
    .in_tuser  (in_tuser),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata (out_tdata),
    .out_tkeep (out_tkeep),
    .out_tlast (out_tlast),
    .out_tuser (out_tuser),
    .owner     (owner),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt)
  );

  beat_t       q[N][$];
  logic [N-1:0] hold;
  int          n_pass = 0;
  int          n_chk = 0;
  int          cyc = 0;
  logic [15:0] log_tag[$];
  int          log_cyc[$];

  // reference model state
  bit          m_valid;
  beat_t       m_beat;
  int          m_last;
  int          m_owner;
  bit          m_lock;
  logic [31:0] m_cnt;

  logic [N-1:0] acc;
  logic [N-1:0] s_rdy;
  logic         s_busy;
  bit           p_stall;
  bit           p_busy;
  beat_t        p_out;
  logic [1:0]   p_owner;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic beat_t mk(input int r, input int p,
                               input int b, input bit last);
    beat_t x;
    logic [15:0] t;
    t = {4'(r), 8'(p), 4'(b)};
    x = '0;
    x.d[15:0] = t;
    x.d[DW-1 -: 16] = ~t;
    x.k = last ? {{(KW-16){1'b0}}, 16'hFFFF} : '1;
    x.l = last;
    x.u = {4'(r), 2'(p), 4'(b)};
    return x;
  endfunction

  task automatic add_pkt(input int r, input int p, input int n);
    for (int b = 0; b < n; b++) q[r].push_back(mk(r, p, b, b == n - 1));
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b = '0;
      if (q[i].size() > 0) b = q[i][0];
      in_tvalid[i] = (q[i].size() > 0) && !hold[i];
      in_tdata[i*DW +: DW] = b.d;
      in_tkeep[i*KW +: KW] = b.k;
      in_tlast[i] = b.l;
      in_tuser[i*UW +: UW] = b.u;
    end
  endtask

  task automatic compare();
    int    cand;
    int    j;
    bit    sf;
    beat_t o;
    logic [N-1:0] exp_rdy;
    sf = !m_valid || out_tready;
    cand = -1;
    if (m_lock) cand = m_owner;
    else begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (cand < 0 && in_tvalid[j] && req_en[j]) cand = j;
      end
    end
    exp_rdy = '0;
    if (sf && cand >= 0) exp_rdy[cand] = 1'b1;
    o = {out_tdata, out_tkeep, out_tlast, out_tuser};
    chk(in_tready == exp_rdy, "in_tready", 64'(in_tready), 64'(exp_rdy));
    chk($onehot0(in_tready), "ready_onehot0", 64'(in_tready), 64'd0);
    chk(out_tvalid == m_valid, "out_tvalid", 64'(out_tvalid), 64'(m_valid));
    if (m_valid) chk(o == m_beat, "out_beat", o.d[63:0], m_beat.d[63:0]);
    chk(owner == 2'(m_owner), "owner", 64'(owner), 64'(m_owner));
    chk(busy == m_lock, "busy", 64'(busy), 64'(m_lock));
    chk(pkt_cnt == m_cnt, "pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    if (p_stall) chk(o == p_out, "stall_hold", o.d[63:0], p_out.d[63:0]);
    if (p_busy) chk(owner == p_owner, "owner_lock", 64'(owner), 64'(p_owner));
    p_stall = out_tvalid && !out_tready;
    p_out   = o;
    p_busy  = busy;
    p_owner = owner;
    s_rdy   = in_tready;
    s_busy  = busy;
    if (out_tvalid && out_tready) begin
      log_tag.push_back(out_tdata[15:0]);
      log_cyc.push_back(cyc);
    end
    if (m_valid && out_tready && m_beat.l) m_cnt = m_cnt + 32'd1;
    if (sf) begin
      if (cand >= 0 && in_tvalid[cand]) begin
        m_valid = 1'b1;
        m_beat  = q[cand][0];
        if (!m_lock) begin
          m_last  = cand;
          m_owner = cand;
        end
        m_lock = !m_beat.l;
      end else m_valid = 1'b0;
    end
    acc = in_tvalid & in_tready;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i]) void'(q[i].pop_front());
  endtask

  task automatic run_until(input int n, input int max);
    int s;
    s = 0;
    while (log_tag.size() < n && s < max) begin
      step();
      s++;
    end
    chk(log_tag.size() >= n, "beat_budget", 64'(log_tag.size()), 64'(n));
  endtask

  task automatic rst_assert();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    hold = '0;
    req_en = '1;
    out_tready = 1'b1;
    m_valid = 1'b0;
    m_beat = '0;
    m_last = N - 1;
    m_owner = 0;
    m_lock = 1'b0;
    m_cnt = '0;
    p_stall = 1'b0;
    p_busy = 1'b0;
    log_tag.delete();
    log_cyc.delete();
    drive();
    @(posedge clk);
  endtask

  task automatic rst_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [15:0] exp3[6];
  int c0;
  int s;

  initial begin
    // reset values with requesters already offering beats
    rst_assert();
    add_pkt(0, 0, 1);
    add_pkt(2, 0, 1);
    drive();
    #1;
    chk(out_tvalid == 1'b0, "rst_tvalid", 64'(out_tvalid), 64'd0);
    chk(out_tdata == '0, "rst_tdata", out_tdata[63:0], 64'd0);
    chk(out_tkeep == '0 && !out_tlast && out_tuser == '0, "rst_fields",
        out_tkeep, 64'd0);
    chk(owner == 2'd0, "rst_owner", 64'(owner), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(pkt_cnt == 32'd0, "rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk(in_tready == '0, "rst_tready", 64'(in_tready), 64'd0);
    rst_release();
    c0 = cyc;
    repeat (4) step();
    chk(log_tag.size() == 2, "t1_count", 64'(log_tag.size()), 64'd2);
    chk(log_tag[0] == 16'h0000, "t1_first", 64'(log_tag[0]), 64'h0000);
    chk(log_tag[1] == 16'h2000, "t1_second", 64'(log_tag[1]), 64'h2000);
    chk(log_cyc[0] == c0 + 1, "t1_latency", 64'(log_cyc[0]), 64'(c0 + 1));
    chk(log_cyc[1] == log_cyc[0] + 1, "t1_no_bubble",
        64'(log_cyc[1]), 64'(log_cyc[0] + 1));
    chk(owner == 2'd2, "t1_owner", 64'(owner), 64'd2);
    chk(pkt_cnt == 32'd2, "t1_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // four requesters, 3-beat packets, strict rotation
    rst_assert();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++) add_pkt(r, p, 3);
    rst_release();
    run_until(24, 80);
    repeat (2) step();
    chk(log_tag.size() == 24, "t2_count", 64'(log_tag.size()), 64'd24);
    chk(log_tag[3] == 16'h1000, "t2_b3", 64'(log_tag[3]), 64'h1000);
    chk(log_tag[11] == 16'h3002, "t2_b11", 64'(log_tag[11]), 64'h3002);
    chk(log_tag[12] == 16'h0010, "t2_b12", 64'(log_tag[12]), 64'h0010);
    chk(log_tag[23] == 16'h3012, "t2_b23", 64'(log_tag[23]), 64'h3012);
    for (int i = 0; i < 24 && i < log_tag.size(); i++)
      chk(log_tag[i] == {4'((i / 3) % 4), 8'(i / 12), 4'(i % 3)},
          "t2_order", 64'(log_tag[i]), 64'(i));
    chk(log_cyc[23] - log_cyc[0] == 23, "t2_throughput",
        64'(log_cyc[23] - log_cyc[0]), 64'd23);
    chk(pkt_cnt == 32'd8, "t2_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // req_en drop mid-packet does not truncate it
    rst_assert();
    add_pkt(1, 0, 4);
    rst_release();
    s = 0;
    while (q[1].size() > 2 && s < 20) begin
      step();
      s++;
    end
    chk(q[1].size() == 2, "t3_midpkt", 64'(q[1].size()), 64'd2);
    req_en[1] = 1'b0;
    add_pkt(3, 0, 2);
    add_pkt(1, 1, 1);
    repeat (15) step();
    exp3 = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h3000, 16'h3001};
    chk(log_tag.size() == 6, "t3_count", 64'(log_tag.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_tag.size(); i++)
      chk(log_tag[i] == exp3[i], "t3_order", 64'(log_tag[i]), 64'(exp3[i]));
    chk(q[1].size() == 1, "t3_blocked", 64'(q[1].size()), 64'd1);
    req_en[1] = 1'b1;
    run_until(7, 10);
    chk(log_tag.size() > 6 && log_tag[6] == 16'h1010, "t3_reenable",
        64'(log_tag.size()), 64'd7);

    // backpressure 1,0,0,1 during a 4-beat packet
    rst_assert();
    add_pkt(2, 0, 4);
    rst_release();
    out_tready = 1'b1;
    step();
    out_tready = 1'b0;
    step();
    chk(s_rdy[2] == 1'b0, "t4_stall1_rdy", 64'(s_rdy), 64'd0);
    step();
    chk(s_rdy[2] == 1'b0, "t4_stall2_rdy", 64'(s_rdy), 64'd0);
    out_tready = 1'b1;
    run_until(4, 20);
    repeat (3) step();
    chk(log_tag.size() == 4, "t4_count", 64'(log_tag.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_tag.size(); i++)
      chk(log_tag[i] == 16'(16'h2000 + i), "t4_order",
          64'(log_tag[i]), 64'(16'h2000 + i));

    // owner stalls its tvalid mid-packet
    rst_assert();
    add_pkt(0, 0, 3);
    add_pkt(1, 0, 1);
    rst_release();
    step();
    hold[0] = 1'b1;
    repeat (5) begin
      step();
      chk(s_busy == 1'b1, "t5_busy", 64'(s_busy), 64'd1);
      chk(s_rdy[1] == 1'b0, "t5_rdy1", 64'(s_rdy), 64'd1);
    end
    hold[0] = 1'b0;
    run_until(4, 20);
    chk(log_tag.size() == 4 && log_tag[2] == 16'h0002 && log_tag[3] == 16'h1000,
        "t5_order", 64'(log_tag.size()), 64'd4);

    // asynchronous reset in the middle of a packet
    rst_assert();
    add_pkt(0, 0, 1);
    add_pkt(0, 1, 4);
    rst_release();
    s = 0;
    while (q[0].size() > 2 && s < 20) begin
      step();
      s++;
    end
    chk(pkt_cnt == 32'd1, "t6_pre_cnt", 64'(pkt_cnt), 64'd1);
    chk(busy == 1'b1, "t6_pre_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk(out_tvalid == 1'b0, "t6_async_tvalid", 64'(out_tvalid), 64'd0);
    chk(pkt_cnt == 32'd0, "t6_async_cnt", 64'(pkt_cnt), 64'd0);
    chk(busy == 1'b0, "t6_async_busy", 64'(busy), 64'd0);
    chk(in_tready == '0, "t6_async_rdy", 64'(in_tready), 64'd0);
    rst_assert();
    add_pkt(3, 0, 1);
    add_pkt(1, 0, 1);
    add_pkt(0, 2, 1);
    rst_release();
    run_until(3, 10);
    chk(log_tag.size() == 3 && log_tag[0] == 16'h0020, "t6_first",
        64'(log_tag.size() > 0 ? log_tag[0] : 16'hFFFF), 64'h0020);
    chk(log_tag.size() == 3 && log_tag[1] == 16'h1000 && log_tag[2] == 16'h3000,
        "t6_rest", 64'(log_tag.size()), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
